alu: RTL and testbench



---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_comb.sv | 56 +++++
 rtl/alu.sv | 37 +++
 tb/tb_alu.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the registered ALU: default width and 4-bit opcode map.
package alu_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int OP_WIDTH      = 4;

    typedef enum logic [OP_WIDTH-1:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_MUL  = 4'b0010,
        OP_DIV  = 4'b0011,
        OP_SHL  = 4'b0100,
        OP_SHR  = 4'b0101,
        OP_ROL  = 4'b0110,
        OP_ROR  = 4'b0111,
        OP_AND  = 4'b1000,
        OP_OR   = 4'b1001,
        OP_XOR  = 4'b1010,
        OP_NOR  = 4'b1011,
        OP_NAND = 4'b1100,
        OP_XNOR = 4'b1101,
        OP_GT   = 4'b1110,
        OP_EQ   = 4'b1111
    } alu_op_e;

endpackage

// File: rtl/alu_comb.sv
// Combinational ALU core: maps operands and opcode to next result and carry/borrow.
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0]    A,
    input  logic [WIDTH-1:0]    B,
    input  logic [OP_WIDTH-1:0] alu_sel,
    output logic [WIDTH-1:0]    result,
    output logic                carry
);

    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   product;
    logic [WIDTH-1:0]     quotient;

    assign sum     = {1'b0, A} + {1'b0, B};
    assign product = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
    // Divide-by-zero saturates to all ones rather than relying on tool-specific behaviour.
    assign quotient = (B == '0) ? '1 : (A / B);

    always_comb begin
        result = '0;
        carry  = 1'b0;
        case (alu_sel)
            OP_ADD:  begin
                result = sum[WIDTH-1:0];
                carry  = sum[WIDTH];
            end
            OP_SUB:  begin
                result = A - B;
                carry  = (A < B);
            end
            OP_MUL:  result = product[WIDTH-1:0];
            OP_DIV:  result = quotient;
            OP_SHL:  result = {A[WIDTH-2:0], 1'b0};
            OP_SHR:  result = {1'b0, A[WIDTH-1:1]};
            OP_ROL:  result = {A[WIDTH-2:0], A[WIDTH-1]};
            OP_ROR:  result = {A[0], A[WIDTH-1:1]};
            OP_AND:  result = A & B;
            OP_OR:   result = A | B;
            OP_XOR:  result = A ^ B;
            OP_NOR:  result = ~(A | B);
            OP_NAND: result = ~(A & B);
            OP_XNOR: result = ~(A ^ B);
            OP_GT:   result = {{(WIDTH-1){1'b0}}, (A > B)};
            OP_EQ:   result = {{(WIDTH-1){1'b0}}, (A == B)};
            default: begin
                result = '0;
                carry  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu.sv
// Registered 4-bit ALU: one-cycle latency from operands/opcode to alu_out/carry_out.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [WIDTH-1:0]    A,
    input  logic [WIDTH-1:0]    B,
    input  logic [OP_WIDTH-1:0] alu_sel,
    output logic [WIDTH-1:0]    alu_out,
    output logic                carry_out
);

    logic [WIDTH-1:0] next_result;
    logic             next_carry;

    alu_comb #(.WIDTH(WIDTH)) u_comb (
        .A       (A),
        .B       (B),
        .alu_sel (alu_sel),
        .result  (next_result),
        .carry   (next_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_out   <= '0;
            carry_out <= 1'b0;
        end else begin
            alu_out   <= next_result;
            carry_out <= next_carry;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed opcode vectors, latency, reset and random traffic.
module tb_alu;

    logic       clk;
    logic       clk_run;
    logic       rst_n;
    logic [3:0] A;
    logic [3:0] B;
    logic [3:0] alu_sel;
    logic [3:0] alu_out;
    logic       carry_out;

    int errors;
    int checks;

    alu dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (A),
        .B         (B),
        .alu_sel   (alu_sel),
        .alu_out   (alu_out),
        .carry_out (carry_out)
    );

    // Gated clock so reset can be exercised with clk stopped
    initial clk = 1'b0;
    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    // Reference model in plain integer arithmetic; returns {carry, result}
    function automatic logic [4:0] model(input int a, input int b, input int sel);
        int r;
        int c;
        r = 0;
        c = 0;
        case (sel)
            0:  begin r = (a + b) % 16; c = (a + b >= 16) ? 1 : 0; end
            1:  begin r = (a - b + 16) % 16; c = (a < b) ? 1 : 0; end
            2:  r = (a * b) % 16;
            3:  r = (b == 0) ? 15 : a / b;
            4:  r = (a * 2) % 16;
            5:  r = a / 2;
            6:  r = (a * 2) % 16 + a / 8;
            7:  r = a / 2 + (a % 2) * 8;
            8:  r = a & b;
            9:  r = a | b;
            10: r = a ^ b;
            11: r = 15 - (a | b);
            12: r = 15 - (a & b);
            13: r = 15 - (a ^ b);
            14: r = (a > b) ? 1 : 0;
            15: r = (a == b) ? 1 : 0;
            default: r = 0;
        endcase
        return {c[0], r[3:0]};
    endfunction

    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic [3:0] sel);
        @(negedge clk);
        A       = a;
        B       = b;
        alu_sel = sel;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(4'd3, 4'd9, 4'd0);
        step();
        // Stop clock low, then pull reset: outputs must clear with no edge
        @(negedge clk);
        clk_run = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (alu_out !== 4'd0 || carry_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: out=%0d carry=%0b expected out=0 carry=0", alu_out, carry_out);
        end
        #3;
        rst_n   = 1'b1;
        A       = 4'd4;
        B       = 4'd11;
        alu_sel = 4'd0;
        #1;
        checks++;
        if (alu_out !== 4'd0 || carry_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: out=%0d carry=%0b expected out=0 carry=0", alu_out, carry_out);
        end
        clk_run = 1'b1;
        step();
        checks++;
        if (alu_out !== 4'd15 || carry_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_edge: out=%0d carry=%0b expected out=15 carry=0", alu_out, carry_out);
        end
        // Reset mid-cycle with the clock running clears at once
        drive(4'd15, 4'd1, 4'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (alu_out !== 4'd0 || carry_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_run: out=%0d carry=%0b expected out=0 carry=0", alu_out, carry_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Each vector packs {a, b, sel, expected result, expected carry}
    task automatic test_directed();
        logic [16:0] vec [26];
        logic [16:0] v;
        vec = '{
            {4'd4,  4'd11, 4'd0,  4'd15, 1'b0},
            {4'd4,  4'd11, 4'd1,  4'd9,  1'b1},
            {4'd4,  4'd11, 4'd2,  4'd12, 1'b0},
            {4'd4,  4'd11, 4'd3,  4'd0,  1'b0},
            {4'd15, 4'd1,  4'd0,  4'd0,  1'b1},
            {4'd9,  4'd0,  4'd3,  4'd15, 1'b0},
            {4'd4,  4'd0,  4'd4,  4'd8,  1'b0},
            {4'd4,  4'd0,  4'd5,  4'd2,  1'b0},
            {4'd7,  4'd0,  4'd6,  4'd14, 1'b0},
            {4'd7,  4'd0,  4'd7,  4'd11, 1'b0},
            {4'd8,  4'd0,  4'd6,  4'd1,  1'b0},
            {4'd1,  4'd0,  4'd7,  4'd8,  1'b0},
            {4'd7,  4'd11, 4'd8,  4'd3,  1'b0},
            {4'd7,  4'd11, 4'd9,  4'd15, 1'b0},
            {4'd7,  4'd11, 4'd10, 4'd12, 1'b0},
            {4'd7,  4'd11, 4'd11, 4'd0,  1'b0},
            {4'd7,  4'd11, 4'd12, 4'd12, 1'b0},
            {4'd7,  4'd11, 4'd13, 4'd3,  1'b0},
            {4'd7,  4'd11, 4'd14, 4'd0,  1'b0},
            {4'd7,  4'd11, 4'd15, 4'd0,  1'b0},
            {4'd11, 4'd7,  4'd14, 4'd1,  1'b0},
            {4'd5,  4'd5,  4'd15, 4'd1,  1'b0},
            {4'd5,  4'd5,  4'd14, 4'd0,  1'b0},
            {4'd5,  4'd5,  4'd1,  4'd0,  1'b0},
            {4'd0,  4'd1,  4'd1,  4'd15, 1'b1},
            {4'd15, 4'd15, 4'd2,  4'd1,  1'b0}
        };
        for (int i = 0; i < 26; i++) begin
            v = vec[i];
            drive(v[16:13], v[12:9], v[8:5]);
            step();
            checks++;
            if (alu_out !== v[4:1] || carry_out !== v[0]) begin
                errors++;
                $display("FAIL directed[%0d] a=%0d b=%0d sel=%0d: out=%0d carry=%0b expected out=%0d carry=%0b",
                         i, v[16:13], v[12:9], v[8:5], alu_out, carry_out, v[4:1], v[0]);
            end
        end
    endtask

    task automatic test_latency();
        logic [4:0] e;
        drive(4'd4, 4'd11, 4'd0);
        step();
        #1;
        alu_sel = 4'd1;
        #1;
        checks++;
        if (alu_out !== 4'd15 || carry_out !== 1'b0) begin
            errors++;
            $display("FAIL latency_hold_sel: out=%0d carry=%0b expected out=15 carry=0", alu_out, carry_out);
        end
        @(negedge clk);
        A = 4'd7;
        #4;
        checks++;
        if (alu_out !== 4'd15 || carry_out !== 1'b0) begin
            errors++;
            $display("FAIL latency_hold_a: out=%0d carry=%0b expected out=15 carry=0", alu_out, carry_out);
        end
        e = model(7, 11, 1);
        step();
        checks++;
        if (alu_out !== e[3:0] || carry_out !== e[4]) begin
            errors++;
            $display("FAIL latency_update: out=%0d carry=%0b expected out=%0d carry=%0b",
                     alu_out, carry_out, e[3:0], e[4]);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] exp_q [$];
        logic [4:0] e;
        int a;
        int b;
        int s;
        for (int i = 0; i < 300; i++) begin
            a = $urandom_range(0, 15);
            b = $urandom_range(0, 15);
            s = $urandom_range(0, 15);
            drive(a[3:0], b[3:0], s[3:0]);
            exp_q.push_back(model(a, b, s));
            step();
            e = exp_q.pop_front();
            checks++;
            if (alu_out !== e[3:0] || carry_out !== e[4]) begin
                errors++;
                $display("FAIL random[%0d] a=%0d b=%0d sel=%0d: out=%0d carry=%0b expected out=%0d carry=%0b",
                         i, a, b, s, alu_out, carry_out, e[3:0], e[4]);
            end
        end
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        clk_run = 1'b1;
        rst_n   = 1'b0;
        A       = 4'd0;
        B       = 4'd0;
        alu_sel = 4'd0;
        #12;
        checks++;
        if (alu_out !== 4'd0 || carry_out !== 1'b0) begin
            errors++;
            $display("FAIL power_on_reset: out=%0d carry=%0b expected out=0 carry=0", alu_out, carry_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_directed();
        test_latency();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
